// File: rtl/tdp_ram_pkg.sv
// Shared types, mode encodings and the byte-lane merge helper for tdp_ram_sync.
package tdp_ram_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} tdp_state_t;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;
    localparam int unsigned PRIO_A  = 0;
    localparam int unsigned PRIO_B  = 1;

    // Upper bounds for the generic merge; callers zero-extend and truncate around it.
    localparam int unsigned MAX_W  = 256;
    localparam int unsigned MAX_NB = 256;

    // Replace the bits of every enabled lane of old_word with new_word.
    function automatic logic [MAX_W-1:0] lane_merge(
        input logic [MAX_W-1:0]  old_word,
        input logic [MAX_W-1:0]  new_word,
        input logic [MAX_NB-1:0] be,
        input int unsigned       byte_w
    );
        logic [MAX_W-1:0] r;
        r = old_word;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (be[8'(i / byte_w)]) begin
                r[8'(i)] = new_word[8'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tdp_ram_sync_rdpipe.sv
// Per-port read-data pipeline: valid strobe, out-of-range zeroing and, with
// TDP_RAM_OUTREG_EN defined, a second output register (read latency 2).
module tdp_ram_rdpipe
    import tdp_ram_pkg::*;
#(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read_en,
    input  logic             in_range,
    input  logic [WIDTH-1:0] rd_word,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid
);

    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    // First stage: capture the array word (or zero for an out-of-range address); hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= read_en;
            if (read_en) begin
                s1_data <= in_range ? rd_word : '0;
            end
        end
    end

`ifdef TDP_RAM_OUTREG_EN
    // Second stage: data and strobe move together; data holds while no strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= s1_valid;
            if (s1_valid) begin
                data_out <= s1_data;
            end
        end
    end
`else
    assign data_out   = s1_data;
    assign data_valid = s1_valid;
`endif

endmodule

// File: rtl/tdp_ram_sync.sv
// True-dual-port synchronous RAM with byte enables, fixed write-collision
// priority and a clear sequencer. Optional macro: TDP_RAM_OUTREG_EN (latency 2).
module tdp_ram_sync
    import tdp_ram_pkg::*;
#(
    parameter int unsigned       WIDTH      = 14,
    parameter int unsigned       DEPTH      = 64,
    parameter int unsigned       BYTE_W     = 7,
    parameter int unsigned       RDW_MODE   = 0,
    parameter int unsigned       COLL_PRIO  = 0,
    parameter logic [WIDTH-1:0]  INIT_VALUE = '0,
    localparam int unsigned      AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned      NB         = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_req,
    output logic             init_busy,
    input  logic [AW-1:0]    a_addr,
    input  logic             a_read_en,
    input  logic             a_write_en,
    input  logic [NB-1:0]    a_byte_en,
    input  logic [WIDTH-1:0] a_data_in,
    output logic [WIDTH-1:0] a_data_out,
    output logic             a_data_valid,
    input  logic [AW-1:0]    b_addr,
    input  logic             b_read_en,
    input  logic             b_write_en,
    input  logic [NB-1:0]    b_byte_en,
    input  logic [WIDTH-1:0] b_data_in,
    output logic [WIDTH-1:0] b_data_out,
    output logic             b_data_valid,
    output logic             collision
);

    localparam bit RD_NEW = (RDW_MODE == RDW_NEW);
    localparam bit A_WINS = (COLL_PRIO != PRIO_B);

    tdp_state_t       state;
    logic [AW-1:0]    clr_addr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             ready, a_in, b_in, a_we, b_we, a_re, b_re, coll;
    logic [AW-1:0]    a_idx, b_idx;
    logic [WIDTH-1:0] a_old, b_old, a_self, b_self, coll_word, a_wr_word;
    logic [WIDTH-1:0] a_rd_word, b_rd_word;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] old_w,
        input logic [WIDTH-1:0] new_w,
        input logic [NB-1:0]    be
    );
        return WIDTH'(lane_merge(MAX_W'(old_w), MAX_W'(new_w), MAX_NB'(be), BYTE_W));
    endfunction

    // Request qualification, lane merging and collision resolution.
    always_comb begin
        ready     = (state == ST_READY);
        a_in      = (32'(a_addr) < DEPTH);
        b_in      = (32'(b_addr) < DEPTH);
        a_idx     = a_in ? a_addr : '0;
        b_idx     = b_in ? b_addr : '0;
        a_we      = ready && a_write_en && a_in;
        b_we      = ready && b_write_en && b_in;
        a_re      = ready && a_read_en;
        b_re      = ready && b_read_en;
        coll      = a_we && b_we && (a_addr == b_addr);
        a_old     = mem[a_idx];
        b_old     = mem[b_idx];
        a_self    = merge(a_old, a_data_in, a_byte_en);
        b_self    = merge(b_old, b_data_in, b_byte_en);
        // Loser's lanes go in first, winner's lanes on top.
        coll_word = A_WINS ? merge(b_self, a_data_in, a_byte_en)
                           : merge(a_self, b_data_in, b_byte_en);
        a_wr_word = coll ? coll_word : a_self;
        a_rd_word = (RD_NEW && a_we) ? a_wr_word : a_old;
        b_rd_word = (RD_NEW && b_we) ? (coll ? coll_word : b_self) : b_old;
    end

    // Clear sequencer FSM, busy flag and collision pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
            collision <= 1'b0;
        end else begin
            collision <= coll;
            if (state == ST_CLEAR) begin
                if (32'(clr_addr) == DEPTH - 1) begin
                    state     <= ST_READY;
                    init_busy <= 1'b0;
                    clr_addr  <= '0;
                end else begin
                    clr_addr <= clr_addr + AW'(1);
                end
            end else if (clear_req) begin
                state     <= ST_CLEAR;
                init_busy <= 1'b1;
                clr_addr  <= '0;
            end
        end
    end

    // Storage array: sweep writes during clear, port writes when ready.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_addr] <= INIT_VALUE;
        end else begin
            if (a_we) begin
                mem[a_idx] <= a_wr_word;
            end
            if (b_we && !coll) begin
                mem[b_idx] <= b_self;
            end
        end
    end

    tdp_ram_rdpipe #(.WIDTH(WIDTH)) u_rdpipe_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (a_re),
        .in_range   (a_in),
        .rd_word    (a_rd_word),
        .data_out   (a_data_out),
        .data_valid (a_data_valid)
    );

    tdp_ram_rdpipe #(.WIDTH(WIDTH)) u_rdpipe_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_en    (b_re),
        .in_range   (b_in),
        .rd_word    (b_rd_word),
        .data_out   (b_data_out),
        .data_valid (b_data_valid)
    );

endmodule
